uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised next-generation UART transmitter for the readout network.
- Buffers words in an internal synchronous FIFO and serialises them LSB-first on TXD.
- Generates its own baud tick from a runtime divisor; no external bit-rate strobe.
- Runtime-configurable data width, parity and stop bits.
- Enforces a programmable idle gap between frames so downstream receivers resynchronise.

Parameters:
- DATA_W, 8, max data bits per frame (5..9); FIFO word width.
- FIFO_DEPTH, 8, FIFO entries, power of 2, >=2.
- DIV_W, 16, width of baud divisor.
- GAP_CYCLES, 16, idle clk cycles (line high) required before every start bit, >=1.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- data_i  in  DATA_W  word to queue
- wr_en_i  in  1  write request; accepted when full_o=0
- baud_div_i  in  DIV_W  bit period = baud_div_i+1 clk cycles; 0 is illegal (treated as 1)
- cfg_bits_i  in  4  data bits per frame, 5..DATA_W; values outside range clamp to the nearest bound
- cfg_parity_i  in  2  00 none, 01 even, 10 odd, 11 none
- cfg_stop2_i  in  1  1 = two stop bits
- full_o  out  1  FIFO full
- empty_o  out  1  FIFO empty
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- ovf_o  out  1  sticky: write attempted while full; cleared only by reset
- busy_o  out  1  frame in progress (any state except IDLE/GAP)
- bps_en_o  out  1  baud counter running (equals busy_o)
- TXD  out  1  serial line, idle high

Behaviour:
- Reset values: TXD=1, full_o=0, empty_o=1, level_o=0, ovf_o=0, busy_o=0, bps_en_o=0.
  - FSM enters GAP with the gap counter at 0.
  - Assertion mid-frame aborts the frame immediately (TXD=1) and flushes the FIFO.
- FIFO:
  - Write accepted iff wr_en_i & ~full_o; data visible to the FSM the next cycle.
  - Write while full is dropped and sets ovf_o. This holds even if a pop occurs in the same cycle, because full is registered.
  - Simultaneous push and pop when not full: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Baud counter:
  - Cleared to 0 outside a frame.
  - Increments each clk while busy. Bit tick fires when count == max(baud_div_i,1); the count then reloads to 0.
- Config latching: cfg_bits_i, cfg_parity_i, cfg_stop2_i and baud_div_i are latched at start; mid-frame changes take effect next frame.
- FSM states: IDLE, GAP, START, DATA, PARITY, STOP.
  - GAP: TXD=1. Counts GAP_CYCLES clk cycles, then moves to IDLE. The counter saturates and does not reset in IDLE.
  - IDLE -> START when ~empty_o. The FIFO pops in the same cycle, and the word and config are registered.
  - TXD goes low on the cycle after the pop.
  - START: TXD=0 for one bit period, then DATA.
  - DATA: shifts out latched bits LSB-first, one per bit period, for cfg_bits bits. Bits above cfg_bits are ignored.
  - DATA -> PARITY if parity is enabled, else -> STOP.
  - PARITY: TXD = XOR of the sent bits (even), or its inverse (odd), for one bit period.
  - STOP: TXD=1 for one or two bit periods, then GAP.
- Frame length: (1+bits+par+stop)*(div+1) clk cycles.
  - The next start bit follows after at least GAP_CYCLES idle cycles, plus 1 cycle for the pop.
- A word written into an empty FIFO during GAP is transmitted as soon as GAP completes. The FIFO never underflows: the FSM pops only when not empty.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined: adds input break_i. If break_i is sampled high in IDLE or GAP:
  - The FSM enters a BREAK state with TXD=0 while break_i stays high.
  - On release it enters GAP, restarting the gap count.
  - A frame in progress completes first.
  - busy_o=1 during BREAK; no FIFO pop occurs.
- Undefined: no break_i port, no BREAK state, and TXD is low only during start bits and 0-valued data/parity bits.

Test Plan:
- Default config (8N1), div=3, write 0xA5 after gap expiry:
  - TXD low 1 cycle after the pop.
  - Bit sequence 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; total 40 cycles; busy_o high for exactly 40 cycles.
- Even parity, 7 bits, 2 stop, div=1, data 0x55:
  - Frame is 0,1,0,1,0,1,0,1, parity=0, 1,1; 22 cycles.
  - Odd parity gives parity bit 1.
- Write 9 words back-to-back with DEPTH=8:
  - full_o=1 after 8 writes and ovf_o=1 after the 9th.
  - Exactly 8 frames are sent, each separated by >=GAP_CYCLES high cycles, in write order.
- Change baud_div_i and cfg_parity_i mid-frame:
  - The current frame keeps its old timing and format.
  - The next frame uses the new values.
- Deassert rstn mid-DATA:
  - TXD=1, FIFO empty, level_o=0, ovf_o=0 immediately.
  - After release there is no transmission for GAP_CYCLES, even with new writes.
- With UART_TX_BREAK_EN, break_i asserted for 50 cycles in IDLE:
  - TXD=0 for those 50 cycles.
  - Then >=GAP_CYCLES high before a queued frame starts.

Source files
------------

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with runtime divisor, width, parity and stop bits.
// Optional UART_TX_BREAK_EN adds break_i and a BREAK state that holds TXD low.
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int GAP_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          wr_en_i,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic [3:0]                    cfg_bits_i,
  input  logic [1:0]                    cfg_parity_i,
  input  logic                          cfg_stop2_i,
`ifdef UART_TX_BREAK_EN
  input  logic                          break_i,
`endif
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          ovf_o,
  output logic                          busy_o,
  output logic                          bps_en_o,
  output logic                          TXD
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [3:0] MAX_BITS = 4'(DATA_W);
  localparam logic [3:0] MIN_BITS = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_START,
    S_DATA,
    S_PARITY,
`ifdef UART_TX_BREAK_EN
    S_STOP,
    S_BREAK
`else
    S_STOP
`endif
  } state_t;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic              r_ovf;
  logic              w_push;
  logic              w_pop;

  state_t            r_state;
  state_t            w_next;
  logic [GW-1:0]     r_gapCnt;
  logic [DIV_W-1:0]  r_baudCnt;
  logic [DIV_W-1:0]  r_div;
  logic              w_busy;
  logic              w_tick;

  logic [DATA_W-1:0] r_shift;
  logic [3:0]        r_nBits;
  logic [3:0]        r_bitIdx;
  logic              r_parEn;
  logic              r_parOdd;
  logic              r_stop2;
  logic              r_stopCnt;
  logic              r_par;
  logic [3:0]        w_cfgBits;

  assign full_o   = (r_level == LW'(FIFO_DEPTH));
  assign empty_o  = (r_level == '0);
  assign level_o  = r_level;
  assign ovf_o    = r_ovf;
  assign w_push   = wr_en_i & ~full_o;
  assign w_busy   = (r_state != S_IDLE) && (r_state != S_GAP);
  assign busy_o   = w_busy;
  assign bps_en_o = w_busy;
  assign w_tick   = w_busy && (r_baudCnt == r_div);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (wr_en_i && full_o) r_ovf <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_cfgBits = cfg_bits_i;
    if (cfg_bits_i < MIN_BITS)      w_cfgBits = MIN_BITS;
    else if (cfg_bits_i > MAX_BITS) w_cfgBits = MAX_BITS;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_GAP: begin
`ifdef UART_TX_BREAK_EN
        if (break_i) w_next = S_BREAK;
        else
`endif
        if (r_gapCnt >= GW'(GAP_CYCLES - 1)) w_next = S_IDLE;
      end
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_i) w_next = S_BREAK;
        else
`endif
        if (!empty_o) begin
          w_pop  = 1'b1;
          w_next = S_START;
        end
      end
      S_START:  if (w_tick) w_next = S_DATA;
      S_DATA:   if (w_tick && (r_bitIdx == r_nBits - 4'd1)) w_next = r_parEn ? S_PARITY : S_STOP;
      S_PARITY: if (w_tick) w_next = S_STOP;
      S_STOP:   if (w_tick && (!r_stop2 || r_stopCnt)) w_next = S_GAP;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  if (!break_i) w_next = S_GAP;
`endif
      default:  w_next = S_GAP;
    endcase
  end

  // Entering GAP from any other state restarts the idle count; it then saturates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_GAP;
      r_gapCnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state != S_GAP && w_next == S_GAP)
        r_gapCnt <= '0;
      else if (r_state == S_GAP && r_gapCnt != GW'(GAP_CYCLES))
        r_gapCnt <= r_gapCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_baudCnt <= '0;
      r_div     <= DIV_W'(1);
      r_shift   <= '0;
      r_nBits   <= MAX_BITS;
      r_bitIdx  <= '0;
      r_parEn   <= 1'b0;
      r_parOdd  <= 1'b0;
      r_stop2   <= 1'b0;
      r_stopCnt <= 1'b0;
      r_par     <= 1'b0;
    end else begin
      if (!w_busy || w_tick) r_baudCnt <= '0;
      else                   r_baudCnt <= r_baudCnt + 1'b1;
      if (w_pop) begin
        r_shift   <= r_mem[r_rptr];
        r_nBits   <= w_cfgBits;
        r_div     <= (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
        r_parEn   <= (cfg_parity_i == 2'b01) || (cfg_parity_i == 2'b10);
        r_parOdd  <= (cfg_parity_i == 2'b10);
        r_stop2   <= cfg_stop2_i;
        r_bitIdx  <= '0;
        r_par     <= 1'b0;
        r_stopCnt <= 1'b0;
      end else if (w_tick) begin
        if (r_state == S_DATA) begin
          r_shift  <= r_shift >> 1;
          r_par    <= r_par ^ r_shift[0];
          r_bitIdx <= r_bitIdx + 1'b1;
        end
        if (r_state == S_STOP) r_stopCnt <= 1'b1;
      end
    end
  end

  always_comb begin
    TXD = 1'b1;
    case (r_state)
      S_START:  TXD = 1'b0;
      S_DATA:   TXD = r_shift[0];
      S_PARITY: TXD = r_par ^ r_parOdd;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  TXD = 1'b0;
`endif
      default:  TXD = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed testbench for uart_tx_param: frame waveforms, FIFO full/overflow, config latching, reset abort.
module tb_uart_tx_param;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 16;
  localparam int GAP_CYCLES = 16;

  logic                         clk = 1'b0;
  logic                         rstn = 1'b1;
  logic [DATA_W-1:0]            dataIn = '0;
  logic                         wrEn = 1'b0;
  logic [DIV_W-1:0]             baudDiv = 16'd3;
  logic [3:0]                   cfgBits = 4'd8;
  logic [1:0]                   cfgParity = 2'b00;
  logic                         cfgStop2 = 1'b0;
  logic                         brk = 1'b0;
  logic                         full;
  logic                         empty;
  logic [$clog2(FIFO_DEPTH):0]  level;
  logic                         ovf;
  logic                         busy;
  logic                         bpsEn;
  logic                         txd;

  int total = 0;
  int bad   = 0;

  uart_tx_param #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .data_i(dataIn),
    .wr_en_i(wrEn),
    .baud_div_i(baudDiv),
    .cfg_bits_i(cfgBits),
    .cfg_parity_i(cfgParity),
    .cfg_stop2_i(cfgStop2),
`ifdef UART_TX_BREAK_EN
    .break_i(brk),
`endif
    .full_o(full),
    .empty_o(empty),
    .level_o(level),
    .ovf_o(ovf),
    .busy_o(busy),
    .bps_en_o(bpsEn),
    .TXD(txd)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle write; returns at the negedge after the capturing posedge.
  task automatic applyStimulus(input logic [DATA_W-1:0] d);
    dataIn = d;
    wrEn   = 1'b1;
    @(negedge clk);
    wrEn   = 1'b0;
  endtask

  task automatic waitStart(input int budget, output int waited, output bit found);
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i <= budget; i++) begin
      if (txd == 1'b0) begin
        found  = 1'b1;
        waited = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic captureFrame(input int n, output logic [63:0] v, output int busyCnt, output int bpsCnt);
    v       = '0;
    v[0]    = txd;
    busyCnt = int'(busy);
    bpsCnt  = int'(bpsEn);
    for (int j = 1; j < n; j++) begin
      @(negedge clk);
      v[j]    = txd;
      busyCnt += int'(busy);
      bpsCnt  += int'(bpsEn);
    end
  endtask

  function automatic logic [63:0] expandBits(input logic [15:0] bits, input int nbits, input int cpb);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < nbits; i++)
      for (int c = 0; c < cpb; c++)
        v[i*cpb + c] = bits[i];
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] v;
    int          busyCnt;
    int          bpsCnt;
    int          waited;
    bit          found;
    logic [7:0]  d;

    #2 rstn = 1'b0;
    #1;
    checkOutput("rst txd",   txd,   1'b1);
    checkOutput("rst full",  full,  1'b0);
    checkOutput("rst empty", empty, 1'b1);
    checkOutput("rst level", level, 0);
    checkOutput("rst ovf",   ovf,   1'b0);
    checkOutput("rst busy",  busy,  1'b0);
    checkOutput("rst bps",   bpsEn, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    $display("[TB] 8N1 div=3 0xA5");
    repeat (30) @(negedge clk);
    applyStimulus(8'hA5);
    checkOutput("s1 pop txd",  txd,  1'b1);
    checkOutput("s1 pop busy", busy, 1'b0);
    waitStart(10, waited, found);
    checkOutput("s1 start lat", waited, 1);
    captureFrame(40, v, busyCnt, bpsCnt);
    checkOutput("s1 wave", v, expandBits(16'b1101001010, 10, 4));
    checkOutput("s1 busy cnt", busyCnt, 40);
    checkOutput("s1 bps cnt",  bpsCnt,  40);
    @(negedge clk);
    checkOutput("s1 end busy", busy, 1'b0);

    $display("[TB] 7E2 / 7O2 div=1");
    cfgBits = 4'd7; cfgParity = 2'b01; cfgStop2 = 1'b1; baudDiv = 16'd1;
    applyStimulus(8'h55);
    waitStart(60, waited, found);
    checkOutput("s2e found", found, 1'b1);
    captureFrame(22, v, busyCnt, bpsCnt);
    checkOutput("s2e wave", v, expandBits(16'b11010101010, 11, 2));
    checkOutput("s2e busy", busyCnt, 22);
    cfgParity = 2'b10;
    applyStimulus(8'hD5);
    waitStart(60, waited, found);
    checkOutput("s2o found", found, 1'b1);
    captureFrame(22, v, busyCnt, bpsCnt);
    checkOutput("s2o wave", v, expandBits(16'b11110101010, 11, 2));

    $display("[TB] FIFO full and overflow");
    cfgBits = 4'd8; cfgParity = 2'b00; cfgStop2 = 1'b0; baudDiv = 16'd1;
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(8'((k + 1) * 17));
      if (k == 7) begin
        checkOutput("s3 full8",  full,  1'b1);
        checkOutput("s3 level8", level, 8);
        checkOutput("s3 ovf8",   ovf,   1'b0);
      end
      if (k == 8) begin
        checkOutput("s3 ovf9",   ovf,   1'b1);
        checkOutput("s3 level9", level, 8);
      end
    end
    for (int k = 0; k < 8; k++) begin
      d = 8'((k + 1) * 17);
      waitStart(300, waited, found);
      checkOutput("s3 found", found, 1'b1);
      if (k > 0) checkOutput("s3 gap", (waited - 1) >= GAP_CYCLES, 1'b1);
      captureFrame(20, v, busyCnt, bpsCnt);
      checkOutput("s3 frame", v, expandBits({7'b0, 1'b1, d, 1'b0}, 10, 2));
    end
    waitStart(100, waited, found);
    checkOutput("s3 no ninth", found, 1'b0);
    checkOutput("s3 empty", empty, 1'b1);

    $display("[TB] mid-frame config change");
    cfgParity = 2'b00; baudDiv = 16'd3;
    applyStimulus(8'h3C);
    applyStimulus(8'hC3);
    waitStart(10, waited, found);
    checkOutput("s4 found1", found, 1'b1);
    baudDiv = 16'd1; cfgParity = 2'b01;
    captureFrame(40, v, busyCnt, bpsCnt);
    checkOutput("s4 frame1", v, expandBits(16'b1001111000, 10, 4));
    waitStart(60, waited, found);
    checkOutput("s4 found2", found, 1'b1);
    captureFrame(22, v, busyCnt, bpsCnt);
    checkOutput("s4 frame2", v, expandBits(16'b10110000110, 11, 2));

    $display("[TB] reset mid-frame");
    cfgParity = 2'b00; baudDiv = 16'd3;
    waitStart(60, waited, found);
    repeat (30) @(negedge clk);
    applyStimulus(8'hF0);
    applyStimulus(8'h0F);
    repeat (8) @(negedge clk);
    checkOutput("s5 pre busy",  busy,  1'b1);
    checkOutput("s5 pre level", level, 1);
    checkOutput("s5 pre ovf",   ovf,   1'b1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("s5 txd",   txd,   1'b1);
    checkOutput("s5 empty", empty, 1'b1);
    checkOutput("s5 level", level, 0);
    checkOutput("s5 ovf",   ovf,   1'b0);
    checkOutput("s5 busy",  busy,  1'b0);
    checkOutput("s5 full",  full,  1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    applyStimulus(8'h5A);
    checkOutput("s5 gap txd0", txd, 1'b1);
    waitStart(100, waited, found);
    checkOutput("s5 found", found, 1'b1);
    checkOutput("s5 gap len", waited >= GAP_CYCLES, 1'b1);
    captureFrame(40, v, busyCnt, bpsCnt);
    checkOutput("s5 frame", v, expandBits({7'b0, 1'b1, 8'h5A, 1'b0}, 10, 4));

    $display("[TB] config clamping");
    cfgBits = 4'd2; baudDiv = 16'd0;
    applyStimulus(8'h1F);
    waitStart(100, waited, found);
    checkOutput("s6 found5", found, 1'b1);
    captureFrame(20, v, busyCnt, bpsCnt);
    checkOutput("s6 clamp5", v, expandBits(16'b1111111110, 10, 2));
    checkOutput("s6 busy5", busyCnt, 14);
    cfgBits = 4'd15; baudDiv = 16'd1;
    applyStimulus(8'h80);
    waitStart(100, waited, found);
    checkOutput("s6 found8", found, 1'b1);
    captureFrame(20, v, busyCnt, bpsCnt);
    checkOutput("s6 clamp8", v, expandBits(16'b1100000000, 10, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
